// File: rtl/piezo_sched.sv
// Prioritised piezo sequencer sharing buzz/buzz_n between error alarm, obstacle warning and arrival chime.
// Optional build macro PIEZO_MUTE_EN adds a mute input that silences the pins without disturbing timing.
module piezo_sched #(
    parameter int TONE_DIV     = 12500,
    parameter int BEEP_CYC     = 5000000,
    parameter int ARRIVE_BEEPS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       err_req,
    input  logic       err_clr,
    input  logic       obst_req,
    input  logic       arrive_req,
`ifdef PIEZO_MUTE_EN
    input  logic       mute,
`endif
    output logic       buzz,
    output logic       buzz_n,
    output logic [1:0] grant,
    output logic       busy
);

    localparam int DUR_W  = $clog2(BEEP_CYC + 1);
    localparam int TONE_W = $clog2(TONE_DIV);

    localparam logic [DUR_W-1:0]  DUR_LAST  = DUR_W'(BEEP_CYC - 1);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);
    localparam logic [TONE_W-1:0] HALF_LAST = TONE_W'(TONE_DIV / 2 - 1);
    localparam logic [3:0]        BEEP_LAST = 4'(ARRIVE_BEEPS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHIME_ON  = 3'd1,
        CHIME_OFF = 3'd2,
        OBST      = 3'd3,
        ERR       = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              err_latch_q, err_latch_d;
    logic              arrive_pend_q, arrive_pend_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [TONE_W-1:0] tone_q, tone_d;
    logic [3:0]        beep_q, beep_d;
    logic              ph_q, ph_d;
    logic              buzz_q, buzz_d;
    logic              buzz_n_q, buzz_n_d;

    logic              in_chime, dur_end, chime_done, entering, snd_d, quiet;
    logic [TONE_W-1:0] tone_lim;

    always_comb begin
        state_d       = state_q;
        err_latch_d   = err_latch_q;
        arrive_pend_d = arrive_pend_q;
        dur_d         = '0;
        tone_d        = '0;
        beep_d        = '0;
        ph_d          = 1'b0;
        quiet         = 1'b0;
`ifdef PIEZO_MUTE_EN
        quiet         = mute;
`endif

        // Set wins over clear when both pulses coincide.
        if (err_req)
            err_latch_d = 1'b1;
        else if (err_clr)
            err_latch_d = 1'b0;

        in_chime   = (state_q == CHIME_ON) || (state_q == CHIME_OFF);
        dur_end    = (dur_q == DUR_LAST);
        chime_done = (state_q == CHIME_OFF) && dur_end && (beep_q == BEEP_LAST);

        // Requests arriving while a chime is already running are absorbed.
        if (chime_done)
            arrive_pend_d = 1'b0;
        else if (arrive_req && !in_chime)
            arrive_pend_d = 1'b1;

        if (err_latch_q)
            state_d = ERR;
        else if (obst_req)
            state_d = OBST;
        else if (arrive_pend_q && !chime_done) begin
            case (state_q)
                CHIME_ON:  state_d = dur_end ? CHIME_OFF : CHIME_ON;
                CHIME_OFF: state_d = dur_end ? CHIME_ON  : CHIME_OFF;
                default:   state_d = CHIME_ON;
            endcase
        end else
            state_d = IDLE;

        entering = (state_d != state_q);

        if ((state_d == CHIME_ON || state_d == CHIME_OFF) && !entering)
            dur_d = dur_q + 1'b1;

        // Beep count survives ON/OFF alternation but restarts when the chime is (re)started.
        if (state_q == CHIME_OFF && state_d == CHIME_ON)
            beep_d = beep_q + 1'b1;
        else if (state_d == CHIME_ON || state_d == CHIME_OFF)
            beep_d = in_chime ? beep_q : 4'd0;

        snd_d    = (state_d == CHIME_ON) || (state_d == OBST) || (state_d == ERR);
        tone_lim = (state_d == ERR) ? HALF_LAST : TONE_LAST;
        if (snd_d) begin
            if (entering) begin
                ph_d   = 1'b1;
                tone_d = '0;
            end else if (tone_q == tone_lim) begin
                ph_d   = ~ph_q;
                tone_d = '0;
            end else begin
                ph_d   = ph_q;
                tone_d = tone_q + 1'b1;
            end
        end

        buzz_d   = snd_d & ph_d & ~quiet;
        buzz_n_d = snd_d & ~ph_d & ~quiet;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            err_latch_q   <= 1'b0;
            arrive_pend_q <= 1'b0;
            dur_q         <= '0;
            tone_q        <= '0;
            beep_q        <= '0;
            ph_q          <= 1'b0;
            buzz_q        <= 1'b0;
            buzz_n_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_latch_q   <= err_latch_d;
            arrive_pend_q <= arrive_pend_d;
            dur_q         <= dur_d;
            tone_q        <= tone_d;
            beep_q        <= beep_d;
            ph_q          <= ph_d;
            buzz_q        <= buzz_d;
            buzz_n_q      <= buzz_n_d;
        end
    end

    always_comb begin
        case (state_q)
            CHIME_ON, CHIME_OFF: grant = 2'b01;
            OBST:                grant = 2'b10;
            ERR:                 grant = 2'b11;
            default:             grant = 2'b00;
        endcase
    end

    assign busy   = (state_q != IDLE) || arrive_pend_q;
    assign buzz   = buzz_q;
    assign buzz_n = buzz_n_q;

endmodule
